exe_stage_unit: RTL and testbench
=================================

# exe_stage_unit

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and computes ALU results and branch targets. It drives `Flush` and `Freeze` back toward the IF/ID side and registers the EXE/MEM pipeline outputs. The optional iterative multiplier stalls the front end while it runs.

## Interface
Parameters:
- `MUL_STEP_BITS`, default 4: multiplier bits consumed per cycle. Legal values are 1, 2, 4, 8. `N_MUL = 32 / MUL_STEP_BITS`.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `Dest_in`  in  5  destination register from ID/EX.
- `Val1_in`, `Val2_in`, `Reg2_in`  in  32 each  operand 1, operand 2 / immediate, store data.
- `PC_in`  in  32  PC+4 of the instruction.
- `Br_taken_in`  in  1  branch resolved taken in ID.
- `EXE_CMD_in`  in  4  operation code.
- `MEM_R_EN_in`, `MEM_W_EN_in`, `WB_EN_in`  in  1 each  control enables.
- `Flush`  out  1  combinational; kills the instructions in IF/ID and ID/EX.
- `Br_addr`  out  32  combinational branch target.
- `Freeze`  out  1  combinational; holds PC, IF/ID and ID/EX.
- `ALU_result`, `ST_val`  out  32 each  registered EXE/MEM outputs.
- `Dest`  out  5  registered.
- `MEM_R_EN`, `MEM_W_EN`, `WB_EN`  out  1 each  registered.

## Operation
- EXE_CMD codes: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLL 1000, SRL 1001, SRA 1010, MUL 1100. Any other code behaves as ADD.
- Arithmetic is 32-bit two's complement. Overflow wraps and no flag is raised.
- Shift amount is `Val2_in[4:0]`. Operand 1 is shifted.
- Branch target: `Br_addr = PC_in + (Val2_in << 2)`, computed modulo 2^32.
- `Flush = Br_taken_in && state==IDLE`. The branch instruction itself still passes to EXE/MEM with its own enables.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with a non-MUL command: result and control are written to EXE/MEM at the next edge.
  - IDLE with MUL: assert `Freeze`. At the edge, capture Val1/Val2, write a bubble to EXE/MEM (all three enables 0, data 0), clear the accumulator and counter, and go to BUSY.
  - BUSY: each cycle, shift-add `MUL_STEP_BITS` multiplier bits. `Freeze`=1. EXE/MEM holds the bubble. After `N_MUL` cycles, go to DONE.
  - DONE: `Freeze`=0. The low 32 bits of the product, plus `Dest`/`WB_EN` from the (still held) ID/EX inputs, are written to EXE/MEM at the edge. Go to IDLE.
- MUL is unsigned-agnostic, since the low 32 bits are the same for signed and unsigned operands.
- While the FSM is in BUSY, the ID/EX inputs are not observed except in DONE.
- Reset value of every registered output is 0. Reset also forces the FSM to IDLE, the counter and accumulator to 0, and `Freeze`/`Flush` to 0 in the reset cycle.
- Reset mid-multiply abandons the operation with no result written.

## Timing
- ALU ops: 1-cycle latency. Inputs in cycle N appear on the EXE/MEM outputs after edge N.
- MUL occupies EXE for `N_MUL + 2` cycles. `Freeze` is high for `N_MUL + 1` consecutive cycles. The result is visible after edge `N_MUL + 1`, counting the acceptance edge as edge 0. With the default parameter this is 10 cycles and `Freeze` is high for 9.
- `Flush` is high for exactly the cycle in which a taken branch sits in ID/EX. Branch and MUL cannot coincide, and `Flush` is gated to IDLE regardless.
- Back-to-back MULs: the second MUL is accepted in the cycle after DONE, so there are no idle gaps beyond the DONE cycle.

## Configuration
- `EXE_MUL_EN` defined:
  - The multiplier and FSM are compiled in, as described above.
- `EXE_MUL_EN` undefined:
  - The FSM and multiplier are absent and `Freeze` is tied to 0.
  - MUL (1100) behaves as ADD.
  - All ops have 1-cycle latency.

## Structure
- `exe_pkg` holds:
  - the EXE_CMD localparams;
  - the FSM state enum;
  - the `DATA_W`=32 and `REG_ADDR_W`=5 constants.
- Sub-module `exe_iter_mul`: a start/busy/done shift-add multiplier parameterized by `MUL_STEP_BITS`.
- The ALU is a combinational always block in the top module.

## Test plan
- ADD `0x7FFFFFFF` + 1, `WB_EN`=1 → `ALU_result`=`0x80000000` one edge later, `WB_EN`=1, `Freeze`=0.
- SRA `Val1`=`0xF0000000`, `Val2`=4 → `0xFF000000`. SRL on the same operands → `0x0F000000`.
- `Br_taken_in`=1, `PC_in`=`0x100`, `Val2_in`=`0xFFFFFFFE` → `Flush`=1 for one cycle, `Br_addr`=`0xF8`.
- MUL 7×6, `Dest`=3, default parameter → `Freeze` high for 9 cycles, bubble in EXE/MEM, then `ALU_result`=42, `Dest`=3, `WB_EN`=1.
- MUL `0xFFFFFFFF` × 2 → `0xFFFFFFFE`. Back-to-back MULs: the second result arrives exactly 10 cycles after the first.
- Assert `rst` in the 4th BUSY cycle → next cycle all outputs 0, `Freeze`=0, FSM IDLE. A following ADD completes normally.

Source files
------------

// File: rtl/exe_stage_unit_pkg.sv
// Shared constants, operation codes and multiplier FSM states for the execute stage.
package exe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] EXE_ADD = 4'b0000;
  localparam logic [3:0] EXE_SUB = 4'b0010;
  localparam logic [3:0] EXE_AND = 4'b0100;
  localparam logic [3:0] EXE_OR  = 4'b0101;
  localparam logic [3:0] EXE_NOR = 4'b0110;
  localparam logic [3:0] EXE_XOR = 4'b0111;
  localparam logic [3:0] EXE_SLL = 4'b1000;
  localparam logic [3:0] EXE_SRL = 4'b1001;
  localparam logic [3:0] EXE_SRA = 4'b1010;
  localparam logic [3:0] EXE_MUL = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/exe_stage_unit_if.sv
// ID/EX inputs, hazard controls and EXE/MEM outputs of the execute stage.
// The master side is the pipeline around the stage; the slave side is the stage itself.
interface exe_stage_unit_if;
  import exe_pkg::*;

  logic [REG_ADDR_W-1:0] Dest_in;
  logic [DATA_W-1:0]     Val1_in;
  logic [DATA_W-1:0]     Val2_in;
  logic [DATA_W-1:0]     Reg2_in;
  logic [DATA_W-1:0]     PC_in;
  logic                  Br_taken_in;
  logic [3:0]            EXE_CMD_in;
  logic                  MEM_R_EN_in;
  logic                  MEM_W_EN_in;
  logic                  WB_EN_in;

  logic                  Flush;
  logic [DATA_W-1:0]     Br_addr;
  logic                  Freeze;
  logic [DATA_W-1:0]     ALU_result;
  logic [DATA_W-1:0]     ST_val;
  logic [REG_ADDR_W-1:0] Dest;
  logic                  MEM_R_EN;
  logic                  MEM_W_EN;
  logic                  WB_EN;

  modport master (
    output Dest_in, Val1_in, Val2_in, Reg2_in, PC_in, Br_taken_in,
           EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
    input  Flush, Br_addr, Freeze, ALU_result, ST_val, Dest,
           MEM_R_EN, MEM_W_EN, WB_EN
  );

  modport slave (
    input  Dest_in, Val1_in, Val2_in, Reg2_in, PC_in, Br_taken_in,
           EXE_CMD_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
    output Flush, Br_addr, Freeze, ALU_result, ST_val, Dest,
           MEM_R_EN, MEM_W_EN, WB_EN
  );

endinterface

// File: rtl/exe_stage_unit_iter_mul.sv
// Iterative shift-add multiplier (low 32 bits), MUL_STEP_BITS multiplier bits per cycle.
// Only compiled when EXE_MUL_EN is defined.
`ifdef EXE_MUL_EN
module exe_iter_mul
  import exe_pkg::*;
#(
  parameter int MUL_STEP_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_mcand,
  input  logic [DATA_W-1:0] i_mplier,
  output logic              o_idle,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int         N_MUL     = DATA_W / MUL_STEP_BITS;
  localparam logic [5:0] LAST_STEP = 6'(N_MUL - 1);

  mul_state_t        r_state;
  mul_state_t        w_nextState;
  logic [5:0]        r_count;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [DATA_W-1:0] w_partial;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = BUSY;
      BUSY:    if (r_count == LAST_STEP) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Partial product of the current multiplicand with the low step of the multiplier.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_STEP_BITS; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_acc    <= '0;
      r_count  <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
    end else if (r_state == BUSY) begin
      r_acc    <= r_acc + w_partial;
      r_mcand  <= r_mcand << MUL_STEP_BITS;
      r_mplier <= r_mplier >> MUL_STEP_BITS;
      r_count  <= r_count + 6'd1;
    end
  end

  assign o_idle    = (r_state == IDLE);
  assign o_busy    = (r_state == BUSY);
  assign o_done    = (r_state == DONE);
  assign o_product = r_acc;

endmodule
`endif

// File: rtl/exe_stage_unit.sv
// MIPS execute stage: ALU, branch target, Flush/Freeze and the EXE/MEM register.
// Define EXE_MUL_EN to build in the iterative multiplier that freezes the front end.
module exe_stage_unit
  import exe_pkg::*;
#(
  parameter int MUL_STEP_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  exe_stage_unit_if.slave bus
);

  if (!(MUL_STEP_BITS == 1 || MUL_STEP_BITS == 2 ||
        MUL_STEP_BITS == 4 || MUL_STEP_BITS == 8)) begin : g_badStep
    $error("exe_stage_unit: MUL_STEP_BITS must be 1, 2, 4 or 8");
  end

  logic [DATA_W-1:0]     w_aluResult;
  logic [4:0]            w_shamt;
  logic                  w_mulIdle;
  logic                  w_mulBusy;
  logic                  w_mulDone;
  logic                  w_mulStart;
  logic [DATA_W-1:0]     w_product;

  logic [DATA_W-1:0]     r_aluResult;
  logic [DATA_W-1:0]     r_stVal;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_memREn;
  logic                  r_memWEn;
  logic                  r_wbEn;

  assign w_shamt = bus.Val2_in[4:0];

  // Unknown codes, and MUL itself, fall through to ADD.
  always_comb begin
    w_aluResult = bus.Val1_in + bus.Val2_in;
    case (bus.EXE_CMD_in)
      EXE_SUB: w_aluResult = bus.Val1_in - bus.Val2_in;
      EXE_AND: w_aluResult = bus.Val1_in & bus.Val2_in;
      EXE_OR:  w_aluResult = bus.Val1_in | bus.Val2_in;
      EXE_NOR: w_aluResult = ~(bus.Val1_in | bus.Val2_in);
      EXE_XOR: w_aluResult = bus.Val1_in ^ bus.Val2_in;
      EXE_SLL: w_aluResult = bus.Val1_in << w_shamt;
      EXE_SRL: w_aluResult = bus.Val1_in >> w_shamt;
      EXE_SRA: w_aluResult = $signed(bus.Val1_in) >>> w_shamt;
      default: w_aluResult = bus.Val1_in + bus.Val2_in;
    endcase
  end

`ifdef EXE_MUL_EN
  assign w_mulStart = w_mulIdle && (bus.EXE_CMD_in == EXE_MUL);

  exe_iter_mul #(
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mulStart),
    .i_mcand   (bus.Val1_in),
    .i_mplier  (bus.Val2_in),
    .o_idle    (w_mulIdle),
    .o_busy    (w_mulBusy),
    .o_done    (w_mulDone),
    .o_product (w_product)
  );
`else
  assign w_mulStart = 1'b0;
  assign w_mulIdle  = 1'b1;
  assign w_mulBusy  = 1'b0;
  assign w_mulDone  = 1'b0;
  assign w_product  = '0;
`endif

  assign bus.Freeze  = !rst && (w_mulStart || w_mulBusy);
  assign bus.Flush   = !rst && bus.Br_taken_in && w_mulIdle;
  assign bus.Br_addr = bus.PC_in + (bus.Val2_in << 2);

  // A multiply holds a bubble in EXE/MEM until its DONE cycle writes the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluResult <= '0;
      r_stVal     <= '0;
      r_dest      <= '0;
      r_memREn    <= 1'b0;
      r_memWEn    <= 1'b0;
      r_wbEn      <= 1'b0;
    end else if (w_mulDone) begin
      r_aluResult <= w_product;
      r_stVal     <= bus.Reg2_in;
      r_dest      <= bus.Dest_in;
      r_memREn    <= bus.MEM_R_EN_in;
      r_memWEn    <= bus.MEM_W_EN_in;
      r_wbEn      <= bus.WB_EN_in;
    end else if (w_mulStart || w_mulBusy) begin
      r_aluResult <= '0;
      r_stVal     <= '0;
      r_dest      <= '0;
      r_memREn    <= 1'b0;
      r_memWEn    <= 1'b0;
      r_wbEn      <= 1'b0;
    end else begin
      r_aluResult <= w_aluResult;
      r_stVal     <= bus.Reg2_in;
      r_dest      <= bus.Dest_in;
      r_memREn    <= bus.MEM_R_EN_in;
      r_memWEn    <= bus.MEM_W_EN_in;
      r_wbEn      <= bus.WB_EN_in;
    end
  end

  assign bus.ALU_result = r_aluResult;
  assign bus.ST_val     = r_stVal;
  assign bus.Dest       = r_dest;
  assign bus.MEM_R_EN   = r_memREn;
  assign bus.MEM_W_EN   = r_memWEn;
  assign bus.WB_EN      = r_wbEn;

endmodule

// File: tb/tb_exe_stage_unit.sv
// Self-checking bench for exe_stage_unit; multiplier scenarios run only when EXE_MUL_EN is defined.
module tb_exe_stage_unit;
  import exe_pkg::*;

  localparam int MUL_STEP_BITS = 4;
  localparam int N_MUL         = 32 / MUL_STEP_BITS;
  localparam int PERIOD        = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nFails  = 0;

  logic [3:0]  curCmd;
  logic [31:0] curA, curB, curReg2, curPc;
  logic        curBr, curMr, curMw, curWb;
  logic [4:0]  curDest;

  logic [3:0] cmdList [12] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hC, 4'h1, 4'hF};

  exe_stage_unit_if bus ();

  exe_stage_unit #(
    .MUL_STEP_BITS (MUL_STEP_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Reference ALU straight from the opcode table.
  function automatic logic [31:0] refAlu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int          s;
    logic [31:0] ones;
    logic [31:0] r;
    s    = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    case (cmd)
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << s;
      4'b1001: r = a >> s;
      4'b1010: begin
        r = a >> s;
        if (a[31]) r = r | ~(ones >> s);
      end
`ifdef EXE_MUL_EN
      4'b1100: r = a * b;
`endif
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [71:0] expStage();
    return {refAlu(curCmd, curA, curB), curReg2, curDest, curMr, curMw, curWb};
  endfunction

  function automatic logic [71:0] obsStage();
    return {bus.ALU_result, bus.ST_val, bus.Dest, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN};
  endfunction

  task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r2, input logic [31:0] pc, input logic br,
                               input logic [4:0] d, input logic mr, input logic mw, input logic wb);
    curCmd = cmd; curA = a; curB = b; curReg2 = r2; curPc = pc;
    curBr = br; curDest = d; curMr = mr; curMw = mw; curWb = wb;
    bus.EXE_CMD_in  = cmd;
    bus.Val1_in     = a;
    bus.Val2_in     = b;
    bus.Reg2_in     = r2;
    bus.PC_in       = pc;
    bus.Br_taken_in = br;
    bus.Dest_in     = d;
    bus.MEM_R_EN_in = mr;
    bus.MEM_W_EN_in = mw;
    bus.WB_EN_in    = wb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(4'b1100, 32'd5, 32'd6, 32'd9, 32'h40, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    nChecks++;
    if ({bus.Freeze, bus.Flush} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL reset_controls: Freeze,Flush=%b expected 00", {bus.Freeze, bus.Flush});
    end
    @(posedge clk); #1;
    nChecks++;
    if (obsStage() !== 72'd0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", obsStage());
    end
    rst = 1'b0;
    applyStimulus(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h1234, 32'h20, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    nChecks++;
    if (bus.Freeze !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL add_freeze: got %b expected 0", bus.Freeze);
    end
    @(posedge clk); #1;
    nChecks++;
    if (bus.ALU_result !== 32'h8000_0000 || bus.WB_EN !== 1'b1 || bus.Dest !== 5'd9) begin
      nFails++;
      $display("[TB] FAIL add_overflow: result=%h wb=%b dest=%0d expected 80000000 1 9",
               bus.ALU_result, bus.WB_EN, bus.Dest);
    end
  endtask

  task automatic test_shifts();
    applyStimulus(4'b1010, 32'hF000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    nChecks++;
    if (bus.ALU_result !== 32'hFF00_0000) begin
      nFails++;
      $display("[TB] FAIL sra: got %h expected ff000000", bus.ALU_result);
    end
    applyStimulus(4'b1001, 32'hF000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    nChecks++;
    if (bus.ALU_result !== 32'h0F00_0000) begin
      nFails++;
      $display("[TB] FAIL srl: got %h expected 0f000000", bus.ALU_result);
    end
  endtask

  task automatic test_branch();
    applyStimulus(4'b0000, 32'd3, 32'hFFFF_FFFE, 32'd7, 32'h100, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    nChecks++;
    if (bus.Flush !== 1'b1 || bus.Br_addr !== 32'h0000_00F8) begin
      nFails++;
      $display("[TB] FAIL branch_taken: Flush=%b Br_addr=%h expected 1 000000f8", bus.Flush, bus.Br_addr);
    end
    @(posedge clk); #1;
    nChecks++;
    if (obsStage() !== expStage()) begin
      nFails++;
      $display("[TB] FAIL branch_passes: got %h expected %h", obsStage(), expStage());
    end
    applyStimulus(4'b0000, 32'd1, 32'd2, 32'd0, 32'h104, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    nChecks++;
    if (bus.Flush !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL branch_one_cycle: Flush=%b expected 0", bus.Flush);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_alu();
    logic [3:0]  cmd;
    logic [31:0] b;
    logic [31:0] expAddr;
    for (int i = 0; i < 150; i++) begin
      cmd = cmdList[$urandom_range(11)];
`ifdef EXE_MUL_EN
      if (cmd == 4'b1100) cmd = 4'b0111;
`endif
      b = $urandom_range(1) ? 32'($urandom_range(31)) : $urandom;
      applyStimulus(cmd, $urandom, b, $urandom, $urandom, ($urandom_range(3) == 0),
                    5'($urandom_range(31)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)));
      expAddr = curPc + curB * 32'd4;
      @(negedge clk);
      nChecks++;
      if ({bus.Flush, bus.Freeze, bus.Br_addr} !== {curBr, 1'b0, expAddr}) begin
        nFails++;
        $display("[TB] FAIL rand_comb[%0d]: Flush,Freeze,Br_addr=%b %b %h expected %b 0 %h",
                 i, bus.Flush, bus.Freeze, bus.Br_addr, curBr, expAddr);
      end
      @(posedge clk); #1;
      nChecks++;
      if (obsStage() !== expStage()) begin
        nFails++;
        $display("[TB] FAIL rand_alu[%0d] cmd=%h: got %h expected %h", i, cmd, obsStage(), expStage());
      end
    end
  endtask

`ifdef EXE_MUL_EN
  task automatic runMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, output time tDone);
    logic [71:0] expVec;
    applyStimulus(4'b1100, a, b, $urandom, $urandom, 1'b0, d, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= N_MUL + 1; k++) begin
      @(negedge clk);
      nChecks++;
      if (bus.Freeze !== (k <= N_MUL)) begin
        nFails++;
        $display("[TB] FAIL mul_freeze cycle %0d: got %b expected %b", k, bus.Freeze, (k <= N_MUL));
      end
      @(posedge clk); #1;
      expVec = (k <= N_MUL) ? 72'd0 : expStage();
      nChecks++;
      if (obsStage() !== expVec) begin
        nFails++;
        $display("[TB] FAIL mul_stage edge %0d: got %h expected %h", k, obsStage(), expVec);
      end
    end
    tDone = $time;
  endtask

  task automatic test_mul();
    time t;
    runMul(32'd7, 32'd6, 5'd3, t);
    nChecks++;
    if (bus.ALU_result !== 32'd42 || bus.Dest !== 5'd3 || bus.WB_EN !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mul_7x6: result=%0d dest=%0d wb=%b expected 42 3 1",
               bus.ALU_result, bus.Dest, bus.WB_EN);
    end
  endtask

  task automatic test_back_to_back();
    time t1, t2;
    runMul(32'hFFFF_FFFF, 32'd2, 5'd5, t1);
    nChecks++;
    if (bus.ALU_result !== 32'hFFFF_FFFE) begin
      nFails++;
      $display("[TB] FAIL mul_neg: got %h expected fffffffe", bus.ALU_result);
    end
    runMul($urandom, $urandom, 5'd7, t2);
    nChecks++;
    if ((t2 - t1) !== time'((N_MUL + 2) * PERIOD)) begin
      nFails++;
      $display("[TB] FAIL mul_b2b_spacing: got %0t expected %0d", t2 - t1, (N_MUL + 2) * PERIOD);
    end
    for (int i = 0; i < 3; i++) runMul($urandom, $urandom, 5'($urandom_range(31)), t1);
  endtask

  task automatic test_reset_mid_mul();
    applyStimulus(4'b1100, 32'd11, 32'd13, 32'd0, 32'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({bus.Freeze, bus.Flush} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL midmul_reset_controls: got %b expected 00", {bus.Freeze, bus.Flush});
    end
    @(posedge clk); #1;
    nChecks++;
    if (obsStage() !== 72'd0) begin
      nFails++;
      $display("[TB] FAIL midmul_reset_outputs: got %h expected 0", obsStage());
    end
    rst = 1'b0;
    for (int k = 0; k < N_MUL + 3; k++) begin
      applyStimulus(4'b0000, $urandom, $urandom, $urandom, 32'd0, 1'b0, 5'($urandom_range(31)),
                    1'b0, 1'b0, 1'b1);
      @(negedge clk);
      nChecks++;
      if (bus.Freeze !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL midmul_after_freeze[%0d]: got %b expected 0", k, bus.Freeze);
      end
      @(posedge clk); #1;
      nChecks++;
      if (obsStage() !== expStage()) begin
        nFails++;
        $display("[TB] FAIL midmul_after_add[%0d]: got %h expected %h", k, obsStage(), expStage());
      end
    end
  endtask
`else
  task automatic test_mul_as_add();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1100, (i == 0) ? 32'd7 : $urandom, (i == 0) ? 32'd6 : $urandom, $urandom,
                    32'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      nChecks++;
      if (bus.Freeze !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL mul_nofreeze[%0d]: got %b expected 0", i, bus.Freeze);
      end
      @(posedge clk); #1;
      nChecks++;
      if (obsStage() !== {curA + curB, curReg2, curDest, 3'b001}) begin
        nFails++;
        $display("[TB] FAIL mul_as_add[%0d]: got %h expected %h", i, obsStage(),
                 {curA + curB, curReg2, curDest, 3'b001});
      end
    end
  endtask
`endif

  initial begin
    #(PERIOD * 20000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_shifts();
    test_branch();
    test_random_alu();
`ifdef EXE_MUL_EN
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
`else
    test_mul_as_add();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
